// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-path types, sizes and Sobel kernel helper
package img_pkg;

  localparam int PIX_W         = 4;
  localparam int IMG_W_DEFAULT = 640;
  localparam int MAG_W         = 7;
  localparam int CNT_W         = 10;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // One window column: top = row y-2, mid = row y-1, bot = row y.
  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } col_t;

  // (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2); each weighted sum is at most 60,
  // so the difference fits a 7-bit signed result.
  function automatic logic signed [MAG_W-1:0] sobel_k(
    input logic [PIX_W-1:0] n0,
    input logic [PIX_W-1:0] n1,
    input logic [PIX_W-1:0] n2,
    input logic [PIX_W-1:0] p0,
    input logic [PIX_W-1:0] p1,
    input logic [PIX_W-1:0] p2
  );
    logic [MAG_W-1:0] w_pos;
    logic [MAG_W-1:0] w_neg;
    w_pos = MAG_W'(p0) + (MAG_W'(p1) << 1) + MAG_W'(p2);
    w_neg = MAG_W'(n0) + (MAG_W'(n1) << 1) + MAG_W'(n2);
    return signed'(w_pos - w_neg);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one-line sync RAM, one write and one read port, read-old-data
module line_buffer_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 4,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdata;

  // Write and registered read; a same-address read returns the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_edge_stream.sv
// rtl/sobel_edge_stream.sv - streaming 3x3 Sobel edge magnitude and thresholded edge flag
module sobel_edge_stream
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [4:0]       i_thresh,
  output logic             o_valid,
  output logic [3:0]       o_edge,
  output logic             o_is_edge
);

  localparam int               AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX  = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [CNT_W-1:0] w_cur_x;
  logic [CNT_W-1:0] w_cur_y;
  logic [4:0]       r_thr;

  logic             r_s1_valid;
  logic             r_s1_border;
  logic [PIX_W-1:0] r_s1_pix;
  logic [AW-1:0]    r_s1_addr;
  logic [4:0]       r_s1_thr;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  col_t             r_c0;
  col_t             r_c1;
  col_t             r_c2;
  logic             r_s2_valid;
  logic             r_s2_border;
  logic [4:0]       r_s2_thr;

  logic signed [MAG_W-1:0] w_gx;
  logic signed [MAG_W-1:0] w_gy;
  logic [MAG_W-1:0]        r_abs_gx;
  logic [MAG_W-1:0]        r_abs_gy;
  logic [MAG_W-1:0]        w_mag;
  logic                    r_s3_valid;
  logic                    r_s3_border;
  logic [4:0]              r_s3_thr;

  // Frame state: once a start of frame is seen the stage never returns to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state, pixel acceptance and the coordinates of the pixel being accepted.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_cur_x      = r_x;
    w_cur_y      = r_y;
    if (i_valid && i_sof) begin
      w_state_next = RUN;
      w_accept     = 1'b1;
      w_cur_x      = '0;
      w_cur_y      = '0;
    end else if (i_valid && (r_state == RUN)) begin
      w_accept     = 1'b1;
    end
  end

  // Column/row counters (row saturates) and the per-frame threshold latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_thr <= '0;
    end else if (w_accept) begin
      if (w_cur_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_cur_y == Y_MAX) ? w_cur_y : w_cur_y + 1'b1;
      end else begin
        r_x <= w_cur_x + 1'b1;
        r_y <= w_cur_y;
      end
      if (i_sof) r_thr <= i_thresh;
    end
  end

  // S1: register the pixel with its column address, border tag and frame threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_pix    <= '0;
      r_s1_addr   <= '0;
      r_s1_thr    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pix    <= i_pix;
        r_s1_addr   <= w_cur_x[AW-1:0];
        r_s1_border <= (w_cur_x < 10'd2) || (w_cur_y < 10'd2);
        r_s1_thr    <= i_sof ? i_thresh : r_thr;
      end
    end
  end

  // lb0 holds row y-1 and lb1 row y-2; each column rolls down one line on write.
  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(AW)) u_lb0 (
    .i_clk   (i_clk),
    .i_we    (r_s1_valid),
    .i_waddr (r_s1_addr),
    .i_wdata (r_s1_pix),
    .i_re    (w_accept),
    .i_raddr (w_cur_x[AW-1:0]),
    .o_rdata (w_lb0_rd)
  );

  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(AW)) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (r_s1_valid),
    .i_waddr (r_s1_addr),
    .i_wdata (w_lb0_rd),
    .i_re    (w_accept),
    .i_raddr (w_cur_x[AW-1:0]),
    .o_rdata (w_lb1_rd)
  );

  // S2: shift the 3x3 window by one column per accepted pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c0        <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_border <= 1'b0;
      r_s2_thr    <= '0;
    end else begin
      if (r_s1_valid) begin
        r_c0 <= r_c1;
        r_c1 <= r_c2;
        r_c2 <= '{top: w_lb1_rd, mid: w_lb0_rd, bot: r_s1_pix};
      end
      r_s2_valid  <= r_s1_valid;
      r_s2_border <= r_s1_border;
      r_s2_thr    <= r_s1_thr;
    end
  end

  assign w_gx = sobel_k(r_c0.top, r_c0.mid, r_c0.bot, r_c2.top, r_c2.mid, r_c2.bot);
  assign w_gy = sobel_k(r_c0.top, r_c1.top, r_c2.top, r_c0.bot, r_c1.bot, r_c2.bot);

  // S3: register the absolute gradients.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_abs_gx    <= '0;
      r_abs_gy    <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_border <= 1'b0;
      r_s3_thr    <= '0;
    end else begin
      r_abs_gx    <= w_gx[MAG_W-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
      r_abs_gy    <= w_gy[MAG_W-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
      r_s3_valid  <= r_s2_valid;
      r_s3_border <= r_s2_border;
      r_s3_thr    <= r_s2_thr;
    end
  end

  assign w_mag = r_abs_gx + r_abs_gy;

  // Output: magnitude and threshold, masked at the frame border, held across bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_edge    <= '0;
      o_is_edge <= 1'b0;
    end else begin
      o_valid <= r_s3_valid;
      if (r_s3_valid) begin
        o_edge    <= r_s3_border ? 4'd0 : w_mag[MAG_W-1:MAG_W-4];
        o_is_edge <= !r_s3_border && (w_mag >= {r_s3_thr, 2'b00});
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb/tb_sobel_edge_stream.sv - self-checking bench for sobel_edge_stream
module tb_sobel_edge_stream;

  localparam int W = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       i_sof;
  logic [3:0] i_pix;
  logic [4:0] i_thresh;
  logic       o_valid;
  logic [3:0] o_edge;
  logic       o_is_edge;

  sobel_edge_stream #(.IMG_W(W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_sof     (i_sof),
    .i_pix     (i_pix),
    .i_thresh  (i_thresh),
    .o_valid   (o_valid),
    .o_edge    (o_edge),
    .o_is_edge (o_is_edge)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;

  typedef struct {
    bit v;
    int x;
    int y;
    int ed;
    bit fl;
  } exp_t;

  bit   m_run;
  int   m_x, m_y, m_thr;
  int   frame [0:31][0:W-1];
  exp_t d0, d1, d2, d3, m_new;

  int   got_e [0:31][0:W-1];
  bit   got_f [0:31][0:W-1];
  bit   rec_on = 1'b0;
  int   seq[$];
  int   ref_seq[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected outputs for the pixel just placed at (x,y): window is rows y-2..y, cols x-2..x.
  function automatic void model_out(input int x, input int y, input int thr,
                                    output int e, output bit f);
    int gx, gy, wt, mag;
    if (x < 2 || y < 2) begin
      e = 0;
      f = 1'b0;
      return;
    end
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++) begin
      wt = (r == 1) ? 2 : 1;
      gx += wt * (frame[(y - 2 + r) % 32][x] - frame[(y - 2 + r) % 32][x - 2]);
      gy += wt * (frame[y % 32][x - 2 + r] - frame[(y - 2) % 32][x - 2 + r]);
    end
    mag = iabs(gx) + iabs(gy);
    e   = mag / 8;
    f   = (mag >= thr * 4);
  endfunction

  // Reference model: track frame position and image, emit expectations 3 clocks later.
  always @(posedge i_clk) begin
    m_new = '{v: 1'b0, x: 0, y: 0, ed: 0, fl: 1'b0};
    if (!i_rst_n) begin
      m_run = 1'b0;
      m_x = 0; m_y = 0; m_thr = 0;
      d0 = m_new; d1 = m_new; d2 = m_new; d3 = m_new;
    end else begin
      if (i_valid && (m_run || i_sof)) begin
        if (i_sof) begin
          m_run = 1'b1; m_x = 0; m_y = 0; m_thr = int'(i_thresh);
        end
        frame[m_y % 32][m_x] = int'(i_pix);
        m_new.v = 1'b1;
        m_new.x = m_x;
        m_new.y = m_y;
        model_out(m_x, m_y, m_thr, m_new.ed, m_new.fl);
        if (m_x == W - 1) begin
          m_x = 0;
          if (m_y < 1023) m_y++;
        end else begin
          m_x++;
        end
      end
      d3 = d2; d2 = d1; d1 = d0; d0 = m_new;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      n_vec++;
      if (o_valid !== 1'b0 || o_edge !== 4'd0 || o_is_edge !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: got valid=%0b edge=%0d flag=%0b, want all 0",
                 o_valid, o_edge, o_is_edge);
      end
    end else begin
      n_vec++;
      if (o_valid !== d3.v) begin
        n_bad++;
        $display("FAIL o_valid @%0t: got %0b, want %0b", $time, o_valid, d3.v);
      end
      if (o_valid === 1'b1) pulses++;
      if (d3.v) begin
        n_vec++;
        if (o_edge !== 4'(d3.ed) || o_is_edge !== d3.fl) begin
          n_bad++;
          $display("FAIL pixel(%0d,%0d): got edge=%0d flag=%0b, want edge=%0d flag=%0b",
                   d3.x, d3.y, o_edge, o_is_edge, d3.ed, d3.fl);
        end
        got_e[d3.y % 32][d3.x] = int'(o_edge);
        got_f[d3.y % 32][d3.x] = o_is_edge;
        if (rec_on) seq.push_back(int'(o_edge) * 2 + int'(o_is_edge));
      end
    end
  end

  task automatic check_lit(input string nm, input int y, input int x, input int e, input bit f);
    n_vec++;
    if (got_e[y][x] != e || got_f[y][x] != f) begin
      n_bad++;
      $display("FAIL %s (%0d,%0d): got edge=%0d flag=%0b, want edge=%0d flag=%0b",
               nm, x, y, got_e[y][x], got_f[y][x], e, f);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic send(input bit sof, input int pix, input int gap);
    i_valid = 1'b1;
    i_sof   = sof;
    i_pix   = 4'(pix);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    repeat (gap) @(negedge i_clk);
  endtask

  // kind 0: flat 9; kind 1: vertical step (cols 0-3 = 0, cols 4-7 = 15).
  task automatic send_frame(input int kind, input int thr, input int thr2, input int chg_row,
                            input int maxgap, input int npix);
    int x, y, pix, gap;
    i_thresh = 5'(thr);
    for (int k = 0; k < npix; k++) begin
      x = k % W;
      y = k / W;
      if (y == chg_row && x == 0) i_thresh = 5'(thr2);
      pix = (kind == 0) ? 9 : ((x >= 4) ? 15 : 0);
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      send(k == 0, pix, gap);
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_sof    = 1'b0;
    i_pix    = '0;
    i_thresh = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    // IDLE: pixels without a start of frame are discarded.
    pulses = 0;
    for (int k = 0; k < 20; k++) send(1'b0, k % 16, 0);
    drain();
    check_val("idle_no_output", pulses, 0);

    // Flat frame: one output per pixel, all zero.
    pulses = 0;
    send_frame(0, 15, 15, 99, 0, 64);
    drain();
    check_val("flat_pulse_count", pulses, 64);
    check_lit("flat_centre", 4, 4, 0, 1'b0);

    // Step frame, threshold 15 (60): edges at x=4,5 for y>=2.
    rec_on = 1'b1;
    seq.delete();
    send_frame(1, 15, 15, 99, 0, 64);
    drain();
    rec_on = 1'b0;
    ref_seq = seq;
    check_lit("step_x4", 2, 4, 7, 1'b1);
    check_lit("step_x5", 7, 5, 7, 1'b1);
    check_lit("step_x6", 3, 6, 0, 1'b0);
    check_lit("step_x3", 4, 3, 0, 1'b0);
    check_lit("border_y1", 1, 4, 0, 1'b0);
    check_lit("border_x1", 5, 1, 0, 1'b0);

    // Threshold 16 (64) is above the step magnitude of 60.
    send_frame(1, 16, 16, 99, 0, 64);
    drain();
    check_lit("thr16_x4", 2, 4, 7, 1'b0);
    check_lit("thr16_x5", 6, 5, 7, 1'b0);

    // Random bubbles must not change the output sequence.
    rec_on = 1'b1;
    seq.delete();
    send_frame(1, 15, 15, 99, 5, 64);
    drain();
    rec_on = 1'b0;
    check_val("bubble_len", seq.size(), ref_seq.size());
    for (int k = 0; k < seq.size() && k < ref_seq.size(); k++)
      check_val($sformatf("bubble_seq[%0d]", k), seq[k], ref_seq[k]);

    // Mid-frame threshold change is ignored until the next start of frame.
    send_frame(1, 15, 31, 3, 0, 64);
    drain();
    check_lit("thr_midframe", 6, 4, 7, 1'b1);
    send_frame(1, 31, 31, 99, 0, 64);
    drain();
    check_lit("thr_next_frame", 6, 4, 7, 1'b0);

    // Re-sync: start of frame at x=3 of row 4, then a full new frame.
    send_frame(1, 15, 15, 99, 0, 35);
    send_frame(1, 15, 15, 99, 0, 64);
    drain();
    check_lit("resync_row0", 0, 4, 0, 1'b0);
    check_lit("resync_row1", 1, 5, 0, 1'b0);
    check_lit("resync_row2", 2, 4, 7, 1'b1);

    // Asynchronous reset mid-stream clears outputs at once.
    send_frame(1, 15, 15, 99, 0, 30);
    @(negedge i_clk);
    @(negedge i_clk);
    @(posedge i_clk);
    #2;
    check_val("pre_reset_valid", int'(o_valid), 1);
    check_val("pre_reset_edge", int'(o_edge), 7);
    i_rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", int'(o_valid), 0);
    check_val("async_rst_edge", int'(o_edge), 0);
    check_val("async_rst_flag", int'(o_is_edge), 0);
    @(negedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // After reset nothing is produced until a start of frame.
    pulses = 0;
    for (int k = 0; k < 20; k++) send(1'b0, 15, 0);
    drain();
    check_val("post_reset_idle", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
